slurm16_mem_arbiter: RTL
========================

Name: slurm16_mem_arbiter

Overview:
- Parametrised N-channel arbiter multiplexing CPU instruction fetch, CPU load/store and future DMA masters onto one synchronous single-port SRAM.
- Successor to the fixed 1-cycle fetch/load memory model. Adds configurable channel count, width and read latency, round-robin fairness, byte masks and per-channel read-data return tagging.
- Sits between slurm16 pipeline/execute memory interfaces and block RAM. Generates per-channel grant (memory_request_successful equivalent) and rvalid (instruction_valid equivalent).

Parameters:
- CHANNELS, 4, number of requesting masters (2..8)
- ADDR_BITS, 15, word address width
- DATA_BITS, 16, data width (multiple of 8)
- READ_LATENCY, 1, memory cycles from mem_re to valid mem_rdata (1..4)

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous active-high reset
- req  in  CHANNELS  per-channel access request, held until granted
- wr  in  CHANNELS  per-channel 1=write, 0=read
- addr  in  CHANNELS*ADDR_BITS  flattened word addresses; channel k at [k*ADDR_BITS +: ADDR_BITS]
- wdata  in  CHANNELS*DATA_BITS  flattened write data
- mask  in  CHANNELS*(DATA_BITS/8)  flattened byte-enable masks
- grant  out  CHANNELS  one-hot; request accepted this cycle
- rvalid  out  CHANNELS  one-hot; read data for channel valid this cycle
- rdata  out  DATA_BITS  shared read-data bus
- mem_addr  out  ADDR_BITS  SRAM address
- mem_wdata  out  DATA_BITS  SRAM write data
- mem_mask  out  DATA_BITS/8  SRAM byte enables
- mem_we  out  1  SRAM write strobe
- mem_re  out  1  SRAM read strobe
- mem_rdata  in  DATA_BITS  SRAM read data

Behaviour:
- Reset: synchronous active-high on RST.
  - Reset values: mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, mem_mask=0, rvalid=0, rdata=0.
  - grant=0 during reset. Round-robin pointer last=CHANNELS-1, so channel 0 wins first.
  - Latency tag pipeline cleared.
- Arbitration:
  - Combinational each cycle. At most one grant bit set.
  - Search order is last+1, last+2, … modulo CHANNELS, wrapping. First channel with req=1 is granted.
  - On grant, last <= granted index at the clock edge. With no request, last is unchanged and grant=0.
- Handshake:
  - A master holds req/wr/addr/wdata/mask stable until it sees grant=1.
  - The transfer completes at that edge. A master may re-request the following cycle.
- Command stage:
  - Granted channel's addr/wdata/mask are registered onto mem_*. mem_we=wr and mem_re=!wr, one cycle after grant (T+1).
  - Both strobes are 0 in cycles with no grant.
- Read return:
  - Tag shift register of depth READ_LATENCY carries {valid, channel index}. Tag enters when mem_re=1.
  - At T+1+READ_LATENCY, rvalid[index]=1 and rdata=mem_rdata, registered-free pass-through of mem_rdata.
  - Throughput is one access per cycle. Back-to-back reads from different channels return in grant order, never reordered.
- Writes produce no rvalid.
- Simultaneous events:
  - rvalid for an old read and grant for a new access in the same cycle are independent and both legal.
  - A read and a write to the same address in consecutive grants follow SRAM order: the write issued later does not affect an earlier read.
- Reset mid-operation: in-flight read tags are discarded. No rvalid is generated for them after RST.
- Unused mask bits are not interpreted by the arbiter; mask passes straight through to mem_mask.

Optional Feature:
- Macro: SLURM16_ARB_CH0_PRIORITY_EN.
- Defined: channel 0 (instruction fetch) has absolute priority. It is granted whenever req[0]=1, and last is not updated by channel 0 grants. Channels 1..N-1 round-robin among themselves when req[0]=0.
- Undefined: pure round-robin across all channels, as described above.

Test Plan:
- Reset then single read: ch1 read addr 0x0010, memory holds 0xBEEF, READ_LATENCY=1 → grant[1] at T, mem_re at T+1, rvalid[1]=1 and rdata=0xBEEF at T+2.
- Round-robin fairness: req=4'b1111 held continuously → grants in order ch0,ch1,ch2,ch3,ch0; no channel is starved over 8 cycles.
- Write with mask: ch2 write addr 0x0005, wdata 0x1234, mask 2'b01 → mem_we=1 and mem_mask=01 at T+1; a subsequent read of 0x0005 over prior 0xFFFF returns 0xFF34; no rvalid for the write.
- Pipelined reads with READ_LATENCY=3: ch0 and ch3 read back-to-back → rvalid[0] at T+4 and rvalid[3] at T+5 with correct data.
- Reset mid-flight: assert RST one cycle after a read grant → no rvalid ever asserted for that read; all outputs 0 during RST.
- With SLURM16_ARB_CH0_PRIORITY_EN: req[0] high for 5 cycles while req[1] and req[2] are high → grant[0] for all 5 cycles; afterwards ch1 then ch2 are granted.

Source files
------------

// File: rtl/slurm16_mem_arbiter_if.sv
// Bus bundle between slurm16 memory masters, the arbiter and the SRAM port.
// slave = arbiter view, master = environment (requesters + SRAM) view.
interface slurm16_mem_arbiter_if #(
  parameter int CHANNELS  = 4,
  parameter int ADDR_BITS = 15,
  parameter int DATA_BITS = 16
);
  localparam int MASK_BITS = DATA_BITS / 8;

  logic [CHANNELS-1:0]           req;
  logic [CHANNELS-1:0]           wr;
  logic [CHANNELS*ADDR_BITS-1:0] addr;
  logic [CHANNELS*DATA_BITS-1:0] wdata;
  logic [CHANNELS*MASK_BITS-1:0] mask;
  logic [CHANNELS-1:0]           grant;
  logic [CHANNELS-1:0]           rvalid;
  logic [DATA_BITS-1:0]          rdata;
  logic [ADDR_BITS-1:0]          mem_addr;
  logic [DATA_BITS-1:0]          mem_wdata;
  logic [MASK_BITS-1:0]          mem_mask;
  logic                          mem_we;
  logic                          mem_re;
  logic [DATA_BITS-1:0]          mem_rdata;

  modport slave (
    input  req, wr, addr, wdata, mask, mem_rdata,
    output grant, rvalid, rdata, mem_addr, mem_wdata, mem_mask, mem_we, mem_re
  );

  modport master (
    output req, wr, addr, wdata, mask, mem_rdata,
    input  grant, rvalid, rdata, mem_addr, mem_wdata, mem_mask, mem_we, mem_re
  );
endinterface

// File: rtl/slurm16_mem_arbiter.sv
// Round-robin N-channel arbiter onto one single-port SRAM with tagged read return.
// Optional macro SLURM16_ARB_CH0_PRIORITY_EN gives channel 0 (fetch) absolute priority.
module slurm16_mem_arbiter #(
  parameter int CHANNELS     = 4,
  parameter int ADDR_BITS    = 15,
  parameter int DATA_BITS    = 16,
  parameter int READ_LATENCY = 1
) (
  input logic                  i_clk,
  input logic                  i_rst,
  slurm16_mem_arbiter_if.slave bus
);
  localparam int MASK_BITS = DATA_BITS / 8;
  localparam int IDX_BITS  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [IDX_BITS-1:0] LAST_INIT = IDX_BITS'(CHANNELS - 1);

  logic [IDX_BITS-1:0]  r_last;
  logic [IDX_BITS-1:0]  w_cand;
  logic [IDX_BITS-1:0]  w_idx;
  logic                 w_any;
  logic                 w_upd_last;
  logic [CHANNELS-1:0]  w_grant;

  logic [ADDR_BITS-1:0] r_mem_addr;
  logic [DATA_BITS-1:0] r_mem_wdata;
  logic [MASK_BITS-1:0] r_mem_mask;
  logic                 r_mem_we;
  logic                 r_mem_re;
  logic [IDX_BITS-1:0]  r_mem_idx;
  logic                 r_tag_v   [READ_LATENCY];
  logic [IDX_BITS-1:0]  r_tag_idx [READ_LATENCY];

  // Search starts one past the previous winner so every requester is reached.
  always_comb begin
    w_any  = 1'b0;
    w_idx  = r_last;
    w_cand = r_last;
    for (int i = 1; i <= CHANNELS; i++) begin
      w_cand = IDX_BITS'((int'(r_last) + i) % CHANNELS);
`ifdef SLURM16_ARB_CH0_PRIORITY_EN
      w_idx = (!w_any && (w_cand != '0) && bus.req[w_cand]) ? w_cand : w_idx;
      w_any = w_any | ((w_cand != '0) & bus.req[w_cand]);
`else
      w_idx = (!w_any && bus.req[w_cand]) ? w_cand : w_idx;
      w_any = w_any | bus.req[w_cand];
`endif
    end
`ifdef SLURM16_ARB_CH0_PRIORITY_EN
    w_idx      = bus.req[0] ? '0 : w_idx;
    w_any      = w_any | bus.req[0];
    w_upd_last = w_any & ~bus.req[0];
`else
    w_upd_last = w_any;
`endif
    w_grant = (w_any && !i_rst) ? ({{(CHANNELS-1){1'b0}}, 1'b1} << w_idx) : '0;
  end

  assign bus.grant     = w_grant;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_mask  = r_mem_mask;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_re    = r_mem_re;

  // Read data is a straight pass-through of the SRAM bus, qualified by the oldest tag.
  always_comb begin
    bus.rvalid = '0;
    bus.rdata  = '0;
    if (r_tag_v[READ_LATENCY-1] && !i_rst) begin
      bus.rvalid[r_tag_idx[READ_LATENCY-1]] = 1'b1;
      bus.rdata                             = bus.mem_rdata;
    end else begin
      bus.rvalid = '0;
      bus.rdata  = '0;
    end
  end

  // Command register, round-robin pointer and read-tag pipeline.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last      <= LAST_INIT;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_mask  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_idx   <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_tag_v[i]   <= 1'b0;
        r_tag_idx[i] <= '0;
      end
    end else begin
      if (w_upd_last) begin
        r_last <= w_idx;
      end
      if (w_any) begin
        r_mem_addr  <= bus.addr[int'(w_idx)*ADDR_BITS +: ADDR_BITS];
        r_mem_wdata <= bus.wdata[int'(w_idx)*DATA_BITS +: DATA_BITS];
        r_mem_mask  <= bus.mask[int'(w_idx)*MASK_BITS +: MASK_BITS];
        r_mem_we    <= bus.wr[w_idx];
        r_mem_re    <= ~bus.wr[w_idx];
        r_mem_idx   <= w_idx;
      end else begin
        r_mem_we <= 1'b0;
        r_mem_re <= 1'b0;
      end
      r_tag_v[0]   <= r_mem_re;
      r_tag_idx[0] <= r_mem_idx;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_tag_v[i]   <= r_tag_v[i-1];
        r_tag_idx[i] <= r_tag_idx[i-1];
      end
    end
  end
endmodule
